// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall (hold) and flush (bubble) support.
// Optional PC field enabled by defining IDEX_PC_TRACE_EN.
module id_ex_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              ID_RegWrite_i,
   input  logic              ID_MemtoReg_i,
   input  logic              ID_MemRead_i,
   input  logic              ID_MemWrite_i,
   input  logic [1:0]        ID_ALUOp_i,
   input  logic              ID_ALUSrc_i,
   input  logic [DATA_W-1:0] ID_RS1data_i,
   input  logic [DATA_W-1:0] ID_RS2data_i,
   input  logic [DATA_W-1:0] ID_Imm_i,
   input  logic [9:0]        ID_funct_i,
   input  logic [REG_AW-1:0] ID_RS1_i,
   input  logic [REG_AW-1:0] ID_RS2_i,
   input  logic [REG_AW-1:0] ID_Rd_i,
`ifdef IDEX_PC_TRACE_EN
   input  logic [DATA_W-1:0] ID_PC_i,
   output logic [DATA_W-1:0] EX_PC_o,
`endif
   output logic              EX_RegWrite_o,
   output logic              EX_MemtoReg_o,
   output logic              EX_MemRead_o,
   output logic              EX_MemWrite_o,
   output logic [1:0]        EX_ALUOp_o,
   output logic              EX_ALUSrc_o,
   output logic [DATA_W-1:0] EX_RS1data_o,
   output logic [DATA_W-1:0] EX_RS2data_o,
   output logic [DATA_W-1:0] EX_Imm_o,
   output logic [9:0]        EX_funct_o,
   output logic [REG_AW-1:0] EX_RS1_o,
   output logic [REG_AW-1:0] EX_RS2_o,
   output logic [REG_AW-1:0] EX_Rd_o,
   output logic              EX_valid_o
);

   // Reset and flush both load the all-zero bubble; register addresses of x0
   // never match in forwarding or hazard compares downstream.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         EX_RegWrite_o <= 1'b0;
         EX_MemtoReg_o <= 1'b0;
         EX_MemRead_o  <= 1'b0;
         EX_MemWrite_o <= 1'b0;
         EX_ALUOp_o    <= '0;
         EX_ALUSrc_o   <= 1'b0;
         EX_RS1data_o  <= '0;
         EX_RS2data_o  <= '0;
         EX_Imm_o      <= '0;
         EX_funct_o    <= '0;
         EX_RS1_o      <= '0;
         EX_RS2_o      <= '0;
         EX_Rd_o       <= '0;
         EX_valid_o    <= 1'b0;
`ifdef IDEX_PC_TRACE_EN
         EX_PC_o       <= '0;
`endif
      end else if (!stall_i) begin
         EX_RegWrite_o <= ID_RegWrite_i;
         EX_MemtoReg_o <= ID_MemtoReg_i;
         EX_MemRead_o  <= ID_MemRead_i;
         EX_MemWrite_o <= ID_MemWrite_i;
         EX_ALUOp_o    <= ID_ALUOp_i;
         EX_ALUSrc_o   <= ID_ALUSrc_i;
         EX_RS1data_o  <= ID_RS1data_i;
         EX_RS2data_o  <= ID_RS2data_i;
         EX_Imm_o      <= ID_Imm_i;
         EX_funct_o    <= ID_funct_i;
         EX_RS1_o      <= ID_RS1_i;
         EX_RS2_o      <= ID_RS2_i;
         EX_Rd_o       <= ID_Rd_i;
         EX_valid_o    <= 1'b1;
`ifdef IDEX_PC_TRACE_EN
         EX_PC_o       <= ID_PC_i;
`endif
      end
   end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus randomized
// rst/stall/flush traffic compared against a transaction-level reference.
module tb_id_ex_pipe_reg;

   typedef struct packed {
      logic        rw, mtr, mr, mw;
      logic [1:0]  aluop;
      logic        alusrc;
      logic [31:0] d1, d2, imm;
      logic [9:0]  funct;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] pc;
      logic        valid;
   } stage_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1, stall = 1'b0, flush = 1'b0;
   stage_t id, exp_q, obs;
   int     checks = 0, errors = 0;

   logic        ex_rw, ex_mtr, ex_mr, ex_mw, ex_alusrc, ex_valid;
   logic [1:0]  ex_aluop;
   logic [31:0] ex_d1, ex_d2, ex_imm;
   logic [9:0]  ex_funct;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
`ifdef IDEX_PC_TRACE_EN
   logic [31:0] ex_pc;
`endif

   always #5 clk = ~clk;

   id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5)) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
      .ID_RegWrite_i(id.rw), .ID_MemtoReg_i(id.mtr), .ID_MemRead_i(id.mr),
      .ID_MemWrite_i(id.mw), .ID_ALUOp_i(id.aluop), .ID_ALUSrc_i(id.alusrc),
      .ID_RS1data_i(id.d1), .ID_RS2data_i(id.d2), .ID_Imm_i(id.imm),
      .ID_funct_i(id.funct), .ID_RS1_i(id.rs1), .ID_RS2_i(id.rs2), .ID_Rd_i(id.rd),
`ifdef IDEX_PC_TRACE_EN
      .ID_PC_i(id.pc), .EX_PC_o(ex_pc),
`endif
      .EX_RegWrite_o(ex_rw), .EX_MemtoReg_o(ex_mtr), .EX_MemRead_o(ex_mr),
      .EX_MemWrite_o(ex_mw), .EX_ALUOp_o(ex_aluop), .EX_ALUSrc_o(ex_alusrc),
      .EX_RS1data_o(ex_d1), .EX_RS2data_o(ex_d2), .EX_Imm_o(ex_imm),
      .EX_funct_o(ex_funct), .EX_RS1_o(ex_rs1), .EX_RS2_o(ex_rs2), .EX_Rd_o(ex_rd),
      .EX_valid_o(ex_valid)
   );

   always_comb begin
      obs        = '0;
      obs.rw     = ex_rw;
      obs.mtr    = ex_mtr;
      obs.mr     = ex_mr;
      obs.mw     = ex_mw;
      obs.aluop  = ex_aluop;
      obs.alusrc = ex_alusrc;
      obs.d1     = ex_d1;
      obs.d2     = ex_d2;
      obs.imm    = ex_imm;
      obs.funct  = ex_funct;
      obs.rs1    = ex_rs1;
      obs.rs2    = ex_rs2;
      obs.rd     = ex_rd;
      obs.valid  = ex_valid;
`ifdef IDEX_PC_TRACE_EN
      obs.pc     = ex_pc;
`endif
   end

   task automatic check_eq(input string tag, input logic [199:0] got, input logic [199:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Reference: one transaction per edge, priority reset > flush > stall > load.
   task automatic step(input logic r, input logic s, input logic f, input string tag);
      @(negedge clk);
      rst = r; stall = s; flush = f;
      @(posedge clk);
      if (r || f) exp_q = '0;
      else if (!s) begin
         exp_q = id;
         exp_q.valid = 1'b1;
`ifndef IDEX_PC_TRACE_EN
         exp_q.pc = '0;
`endif
      end
      #1;
      check_eq(tag, 200'(obs), 200'(exp_q));
   endtask

   function automatic stage_t rand_id();
      stage_t t;
      t.rw = 1'($urandom); t.mtr = 1'($urandom); t.mr = 1'($urandom); t.mw = 1'($urandom);
      t.aluop = 2'($urandom); t.alusrc = 1'($urandom);
      t.d1 = $urandom; t.d2 = $urandom; t.imm = $urandom;
      t.funct = 10'($urandom);
      t.rs1 = 5'($urandom); t.rs2 = 5'($urandom); t.rd = 5'($urandom);
      t.pc = $urandom; t.valid = 1'b0;
      return t;
   endfunction

   initial begin
      exp_q = '0;
      // Reset with all-ones inputs
      id = '1;
      step(1'b1, 1'b0, 1'b0, "reset1");
      check_eq("reset1_valid", 200'(ex_valid), 200'd0);
      step(1'b1, 1'b0, 1'b0, "reset2");

      // Pass-through
      id = '0;
      id.rs1 = 5'd5; id.rs2 = 5'd6; id.rd = 5'd7; id.rw = 1'b1; id.imm = 32'hFFFF_FFF0;
      step(1'b0, 1'b0, 1'b0, "pass");
      check_eq("pass_rs1", 200'(ex_rs1), 200'd5);
      check_eq("pass_rs2", 200'(ex_rs2), 200'd6);
      check_eq("pass_rd", 200'(ex_rd), 200'd7);
      check_eq("pass_rw", 200'(ex_rw), 200'd1);
      check_eq("pass_imm", 200'(ex_imm), 200'hFFFF_FFF0);
      check_eq("pass_valid", 200'(ex_valid), 200'd1);

      // Stall holds for 3 cycles, then new Rd appears
      id.rd = 5'd9;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, "stall");
         check_eq("stall_rd", 200'(ex_rd), 200'd7);
      end
      step(1'b0, 1'b0, 1'b0, "unstall");
      check_eq("unstall_rd", 200'(ex_rd), 200'd9);

      // Flush a load in EX
      id = rand_id();
      id.mr = 1'b1; id.rw = 1'b1; id.rd = 5'd3; id.rs1 = 5'd4;
      step(1'b0, 1'b0, 1'b0, "load");
      id = rand_id();
      step(1'b0, 1'b0, 1'b1, "flush");
      check_eq("flush_mr", 200'(ex_mr), 200'd0);
      check_eq("flush_rw", 200'(ex_rw), 200'd0);
      check_eq("flush_rd", 200'(ex_rd), 200'd0);
      check_eq("flush_rs1", 200'(ex_rs1), 200'd0);
      check_eq("flush_valid", 200'(ex_valid), 200'd0);

      // Flush and stall together
      id = rand_id();
      step(1'b0, 1'b0, 1'b0, "load2");
      id = rand_id();
      step(1'b0, 1'b1, 1'b1, "flush_stall");
      check_eq("flush_stall_all", 200'(obs), 200'd0);

      // Bubble stays a bubble under stall
      step(1'b0, 1'b1, 1'b0, "stall_bubble");
      check_eq("stall_bubble_valid", 200'(ex_valid), 200'd0);

      // Reset mid-stall
      id = rand_id();
      step(1'b0, 1'b0, 1'b0, "load3");
      step(1'b0, 1'b1, 1'b0, "stall3");
      step(1'b1, 1'b1, 1'b0, "rst_stall");
      check_eq("rst_stall_all", 200'(obs), 200'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         id = rand_id();
         step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 4) == 0), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
